// File: rtl/memory_responder.sv
// Wait-stated 32-bit synchronous RAM slave for the control unit's ReadRAM/WriteRAM handshake.
// A request is accepted once per arming, so a strobe held past Done never repeats an access.
module memory_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReadRAM,
  input  logic        WriteRAM,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic        Busy,
  output logic        Error
);

  localparam int unsigned LP_DEPTH = 1 << ADDR_W;
  localparam logic [3:0]  LP_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [3:0]          r_count,    w_count_nxt;
  logic                r_armed,    w_armed_nxt;
  logic                r_is_write, w_is_write_nxt;
  logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
  logic [31:0]         r_wdata,    w_wdata_nxt;
  logic                r_error,    w_error_nxt;
  logic                w_do_access;
  logic [31:0]         r_read_data;
  logic [31:0]         r_mem [LP_DEPTH];

  // Upper MAR bits are don't-care: addresses wrap modulo the RAM depth.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^Address[31:ADDR_W];

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_armed_nxt    = r_armed;
    w_is_write_nxt = r_is_write;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_error_nxt    = 1'b0;
    w_do_access    = 1'b0;

    case (r_state)
      IDLE: begin
        if (ReadRAM && WriteRAM) begin
          if (r_armed) begin
            w_error_nxt = 1'b1;
            w_armed_nxt = 1'b0;
          end
        end else if (ReadRAM || WriteRAM) begin
          if (r_armed) begin
            w_is_write_nxt = WriteRAM;
            w_addr_nxt     = Address[ADDR_W-1:0];
            w_wdata_nxt    = WriteData;
            w_count_nxt    = LP_WAIT;
            w_state_nxt    = ACCESS;
          end
        end else begin
          w_armed_nxt = 1'b1;
        end
      end

      ACCESS: begin
        if (r_count != 4'd0) begin
          w_count_nxt = r_count - 4'd1;
        end else begin
          w_do_access = 1'b1;
          w_state_nxt = RESPOND;
        end
      end

      RESPOND: begin
        w_state_nxt = IDLE;
        w_armed_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_armed    <= 1'b1;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_armed    <= w_armed_nxt;
      r_is_write <= w_is_write_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // NOTE: the RAM array has no reset; contents survive Reset and an aborted write never reaches it.
  always_ff @(posedge Clock) begin
    if (w_do_access && r_is_write) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_read_data <= 32'd0;
    end else if (w_do_access && !r_is_write) begin
      r_read_data <= r_mem[r_addr];
    end
  end

  assign ReadData = r_read_data;
  assign Done     = (r_state == RESPOND);
  assign Busy     = (r_state != IDLE);
  assign Error    = r_error;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a default (2 wait-state) instance driven from a vector
// table plus hand sequences, and a zero-wait-state instance for the minimum-latency case.
module tb_memory_responder;

  localparam int unsigned W0 = 2;

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BOTH} op_e;

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;

  logic        ReadRAM = 1'b0, WriteRAM = 1'b0;
  logic [31:0] Address = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Done, Busy, Error;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        done1, busy1, error1;

  int n_vec = 0;
  int n_err = 0;

  memory_responder #(.ADDR_W(9), .WAIT_CYCLES(W0)) dut (
    .Clock(Clock), .Reset(Reset), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Done(Done), .Busy(Busy), .Error(Error)
  );

  memory_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0w (
    .Clock(Clock), .Reset(Reset), .ReadRAM(rd1), .WriteRAM(wr1),
    .Address(addr1), .WriteData(wdata1), .ReadData(rdata1),
    .Done(done1), .Busy(busy1), .Error(error1)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One request on the 2-wait instance; returns with the block idle and re-armed.
  task automatic do_req(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input string tag);
    int lat;
    int busy_n;
    bit seen;
    Address   = addr;
    WriteData = wdata;
    ReadRAM   = (op != OP_WR);
    WriteRAM  = (op != OP_RD);
    @(posedge Clock); #1;
    if (op == OP_BOTH) begin
      check({tag, " error pulse"}, {31'd0, Error}, 32'd1);
      check({tag, " busy idle"}, {31'd0, Busy}, 32'd0);
      ReadRAM  = 1'b0;
      WriteRAM = 1'b0;
      @(posedge Clock); #1;
      check({tag, " error one cycle"}, {31'd0, Error}, 32'd0);
      check({tag, " rdata kept"}, ReadData, exp_rdata);
    end else begin
      // Scramble inputs mid-access; the latched request must be used.
      Address   = ~addr;
      WriteData = ~wdata;
      busy_n = Busy ? 1 : 0;
      lat    = 0;
      seen   = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
        @(posedge Clock); #1;
        if (Busy) busy_n++;
        if (Done) begin
          seen = 1'b1;
          lat  = k;
        end
      end
      check({tag, " done latency"}, lat, W0 + 1);
      check({tag, " busy cycles"}, busy_n, W0 + 2);
      check({tag, " rdata"}, ReadData, exp_rdata);
      ReadRAM  = 1'b0;
      WriteRAM = 1'b0;
      @(posedge Clock); #1;
      check({tag, " done one cycle"}, {30'd0, Done, Busy}, 32'd0);
      @(posedge Clock); #1;
    end
  endtask

  vec_t vecs[10];

  initial begin
    int pulses;

    vecs[0] = '{OP_WR,   32'h0000_0025, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{OP_RD,   32'h0000_0025, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{OP_BOTH, 32'h0000_0025, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3] = '{OP_RD,   32'h0000_0025, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[4] = '{OP_WR,   32'h0000_0203, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[5] = '{OP_RD,   32'h0000_0003, 32'h0000_0000, 32'h1234_5678};
    vecs[6] = '{OP_WR,   32'hFFFF_FFFF, 32'hA5A5_0F0F, 32'h1234_5678};
    vecs[7] = '{OP_RD,   32'h0000_01FF, 32'h0000_0000, 32'hA5A5_0F0F};
    vecs[8] = '{OP_WR,   32'h0000_0000, 32'h0000_0001, 32'hA5A5_0F0F};
    vecs[9] = '{OP_RD,   32'h8000_0200, 32'h0000_0000, 32'h0000_0001};

    #12;
    check("reset outputs", {ReadData[30:0], Done | Busy | Error}, 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // First vector starts immediately: acceptance at the first edge after reset.
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end
    do_req(OP_RD, 32'h0000_0025, 32'h0, 32'hDEAD_BEEF, "wrap kept 0x25");

    // Held strobe: one access only, then a single low IDLE edge re-arms.
    Address = 32'h0000_0003;
    ReadRAM = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge Clock); #1;
      if (Done) pulses++;
    end
    check("held strobe done pulses", pulses, 1);
    check("held strobe no re-access", {31'd0, Busy}, 32'd0);
    ReadRAM = 1'b0;
    @(posedge Clock); #1;
    Address = 32'h0000_0025;
    ReadRAM = 1'b1;
    @(posedge Clock); #1;
    check("re-armed accept", {31'd0, Busy}, 32'd1);
    for (int k = 0; k < 20 && !Done; k++) begin
      @(posedge Clock); #1;
    end
    check("re-armed read", ReadData, 32'hDEAD_BEEF);
    ReadRAM = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;

    // Reset during the ACCESS phase of a write aborts it.
    do_req(OP_WR, 32'h0000_0040, 32'h0000_0011, 32'hDEAD_BEEF, "pre-reset write");
    Address   = 32'h0000_0040;
    WriteData = 32'hFFFF_FFFF;
    WriteRAM  = 1'b1;
    @(posedge Clock); #1;
    check("abort write busy", {31'd0, Busy}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("async reset rdata", ReadData, 32'd0);
    check("async reset flags", {29'd0, Done, Busy, Error}, 32'd0);
    WriteRAM = 1'b0;
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset = 1'b0;
    do_req(OP_RD, 32'h0000_0040, 32'h0, 32'h0000_0011, "after abort");

    // Zero-wait instance: request at edge N, Done from N+1 to N+2.
    addr1  = 32'h0000_0005;
    wdata1 = 32'h0BAD_F00D;
    wr1    = 1'b1;
    @(posedge Clock); #1;
    check("w0 write accept", {30'd0, busy1, done1}, 32'b10);
    @(posedge Clock); #1;
    check("w0 write done N+1", {30'd0, busy1, done1}, 32'b11);
    wr1 = 1'b0;
    @(posedge Clock); #1;
    check("w0 write done N+2", {30'd0, busy1, done1}, 32'b00);
    @(posedge Clock); #1;
    rd1 = 1'b1;
    @(posedge Clock); #1;
    check("w0 read accept", {30'd0, busy1, done1}, 32'b10);
    @(posedge Clock); #1;
    check("w0 read done N+1", {30'd0, busy1, done1}, 32'b11);
    check("w0 read data", rdata1, 32'h0BAD_F00D);
    rd1 = 1'b0;
    @(posedge Clock); #1;
    check("w0 read done N+2", {29'd0, busy1, done1, error1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
